tdm_demux1x4: RTL

Time-division demultiplexer: the receive-side counterpart of the 4:1 multiplexer. It takes one interleaved sample stream carrying four channels in slot order 0,1,2,3 and rebuilds the four parallel channel outputs. Frame alignment comes from a slot-0 marker (`frame_sync`). The block sits downstream of a 4:1 mux or serializer and publishes one complete, registered four-channel frame per `frame_valid` pulse.

---
 rtl/tdm_demux_pkg.sv | 13 +
 rtl/tdm_slot_ctr.sv | 39 +++
 rtl/tdm_demux1x4.sv | 136 +++++++++++++
 3 files changed

// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg: shared constants and FSM state type for the 1:4 TDM
// demultiplexer (tdm_demux1x4) and its slot counter (tdm_slot_ctr).
package tdm_demux_pkg;

    localparam int N_CH   = 4;
    localparam int SLOT_W = 2;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: 2-bit slot counter for the TDM demultiplexer.
//   clk, rst : clock, asynchronous active-high reset (counter -> 0)
//   en       : advance to the next slot (wraps 3 -> 0)
//   load1    : synchronous load of slot 1 (frame acquire / resync);
//              takes priority over en
//   slot     : current slot index
//   wrap     : high while slot == 3 (next advance completes a frame)
module tdm_slot_ctr
    import tdm_demux_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load1,
    output logic [SLOT_W-1:0] slot,
    output logic              wrap
);

    logic [SLOT_W-1:0] slot_q, slot_d;

    always_comb begin
        slot_d = slot_q;
        if (load1)
            slot_d = SLOT_W'(1);
        else if (en)
            slot_d = slot_q + SLOT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            slot_q <= '0;
        else
            slot_q <= slot_d;
    end

    assign slot = slot_q;
    assign wrap = (slot_q == SLOT_W'(N_CH - 1));

endmodule

// File: rtl/tdm_demux1x4.sv
// tdm_demux1x4: 1:4 time-division demultiplexer. Rebuilds four parallel
// channels from an interleaved stream (slot order 0,1,2,3) aligned by a
// slot-0 marker, and publishes one registered frame per frame_valid pulse.
//   clk, rst      : clock, asynchronous active-high reset
//   din           : interleaved sample, valid when din_valid
//   frame_sync    : current sample is slot 0
//   out0..out3    : channel outputs of the last complete frame
//   frame_valid   : one-cycle pulse when out0..out3 update
//   slot          : slot index expected for the next accepted sample
//   locked        : FSM is in LOCKED
//   sync_err      : one-cycle pulse on resync or on a flywheel slot 0
//                   (only when TDM_DEMUX_SYNC_ERR_EN is defined)
module tdm_demux1x4
    import tdm_demux_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              frame_sync,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic [DATA_W-1:0] out3,
    output logic              frame_valid,
`ifdef TDM_DEMUX_SYNC_ERR_EN
    output logic              sync_err,
`endif
    output logic [SLOT_W-1:0] slot,
    output logic              locked
);

    state_e                          state_q, state_d;
    logic [SLOT_W-1:0]               slot_cnt;
    logic                            slot_wrap;
    logic                            ctr_en, ctr_load;
    logic [N_CH-2:0][DATA_W-1:0]     shadow_q, shadow_d;
    logic [N_CH-1:0][DATA_W-1:0]     out_q, out_d;
    logic                            frame_valid_q, frame_valid_d;

    tdm_slot_ctr u_slot_ctr (
        .clk   (clk),
        .rst   (rst),
        .en    (ctr_en),
        .load1 (ctr_load),
        .slot  (slot_cnt),
        .wrap  (slot_wrap)
    );

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        out_d         = out_q;
        frame_valid_d = 1'b0;
        ctr_en        = 1'b0;
        ctr_load      = 1'b0;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        shadow_d[0] = din;
                        ctr_load    = 1'b1;
                        state_d     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync && slot_cnt != '0) begin
                        // Resync: restart the frame here, dropping the partial one.
                        shadow_d[0] = din;
                        ctr_load    = 1'b1;
                    end else begin
                        // Normal slot, or flywheel through a missing slot-0 marker.
                        ctr_en = 1'b1;
                        if (slot_wrap) begin
                            out_d[0]      = shadow_q[0];
                            out_d[1]      = shadow_q[1];
                            out_d[2]      = shadow_q[2];
                            out_d[3]      = din;
                            frame_valid_d = 1'b1;
                        end else begin
                            for (int s = 0; s < N_CH - 1; s++)
                                if (slot_cnt == SLOT_W'(s))
                                    shadow_d[s] = din;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HUNT;
            shadow_q      <= '0;
            out_q         <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            out_q         <= out_d;
            frame_valid_q <= frame_valid_d;
        end
    end

`ifdef TDM_DEMUX_SYNC_ERR_EN
    logic sync_err_q, sync_err_d;

    // While locked, the marker must coincide with slot 0: a marker elsewhere
    // is a resync, a slot 0 without it is a flywheel. Both are flagged.
    always_comb begin
        sync_err_d = din_valid && (state_q == LOCKED) &&
                     (frame_sync != (slot_cnt == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sync_err_q <= 1'b0;
        else
            sync_err_q <= sync_err_d;
    end

    assign sync_err = sync_err_q;
`endif

    assign out0        = out_q[0];
    assign out1        = out_q[1];
    assign out2        = out_q[2];
    assign out3        = out_q[3];
    assign frame_valid = frame_valid_q;
    assign slot        = slot_cnt;
    assign locked      = (state_q == LOCKED);

endmodule
